// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus arbiter: grant encoding used by the arbiter, decoders and bench.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FETCH = 2'b01,
    GNT_DATA  = 2'b10
  } grant_t;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Fetch, data and external-bus signals of the CPU bus arbiter, bundled into one interface.
interface cpu_bus_arbiter_if;
  import cpu_bus_pkg::*;

  logic        i_fetch_request;
  logic [31:0] i_fetch_address;
  logic        o_fetch_ready;
  logic [31:0] o_fetch_rdata;

  logic        i_data_request;
  logic        i_data_rw;
  logic [31:0] i_data_address;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_wmask;
  logic        o_data_ready;
  logic [31:0] o_data_rdata;

  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  grant_t      o_grant;

  // Arbiter side
  modport slave (
    input  i_fetch_request, i_fetch_address,
    output o_fetch_ready, o_fetch_rdata,
    input  i_data_request, i_data_rw, i_data_address, i_data_wdata, i_data_wmask,
    output o_data_ready, o_data_rdata,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
    input  i_bus_ready, i_bus_rdata,
    output o_grant
  );

  // Requester / bus-model side
  modport master (
    output i_fetch_request, i_fetch_address,
    input  o_fetch_ready, o_fetch_rdata,
    output i_data_request, i_data_rw, i_data_address, i_data_wdata, i_data_wmask,
    input  o_data_ready, o_data_rdata,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
    output i_bus_ready, i_bus_rdata,
    input  o_grant
  );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU memory bus between ICache refill and the data path, one transaction at a time,
// data first with a starvation counter that eventually forces a waiting fetch through.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no owner; arbitrates the requests sampled this cycle
// S_FETCH   | fetch owns the bus until i_bus_ready
// S_DATA    | data path owns the bus until i_bus_ready
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CW           = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  cpu_bus_arbiter_if.slave  bus
);

  localparam logic [1:0]    S_IDLE  = 2'b00;
  localparam logic [1:0]    S_FETCH = 2'b01;
  localparam logic [1:0]    S_DATA  = 2'b10;
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          fetch_forced;
  logic          fetch_gnt;
  logic          data_gnt;

  assign fetch_forced = bus.i_fetch_request && (starve_q >= LIMIT);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_data_request && !fetch_forced) begin
          state_d = S_DATA;
          if (!bus.i_fetch_request) begin
            starve_d = '0;
          end else if (starve_q < LIMIT) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (bus.i_fetch_request) begin
          state_d  = S_FETCH;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      S_FETCH, S_DATA: begin
        if (bus.i_bus_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Outputs are gated by i_reset so the bus is released in the same cycle reset asserts.
  assign fetch_gnt = i_reset && (state_q == S_FETCH);
  assign data_gnt  = i_reset && (state_q == S_DATA);

  always_comb begin
    bus.o_bus_request = fetch_gnt || data_gnt;
    bus.o_bus_rw      = 1'b0;
    bus.o_bus_address = '0;
    bus.o_bus_wdata   = '0;
    bus.o_bus_wmask   = '0;
    bus.o_grant       = GNT_NONE;
    if (fetch_gnt) begin
      bus.o_bus_address = bus.i_fetch_address;
      bus.o_grant       = GNT_FETCH;
    end
    if (data_gnt) begin
      bus.o_bus_rw      = bus.i_data_rw;
      bus.o_bus_address = bus.i_data_address;
      bus.o_bus_wdata   = bus.i_data_wdata;
      bus.o_bus_wmask   = bus.i_data_wmask;
      bus.o_grant       = GNT_DATA;
    end
  end

  always_comb begin
    bus.o_fetch_ready = fetch_gnt && bus.i_bus_ready;
    bus.o_data_ready  = data_gnt && bus.i_bus_ready;
    bus.o_fetch_rdata = bus.o_fetch_ready ? bus.i_bus_rdata : '0;
    bus.o_data_rdata  = bus.o_data_ready  ? bus.i_bus_rdata : '0;
  end

endmodule
